// File: rtl/mollusc_pkg.sv
// Shared constants and types for the issue scoreboard and its neighbours.
package mollusc_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int LAT_W      = 2;
  localparam int NUM_PORTS  = 4;

  // Read-port bit positions inside packed {a,b,m,p} vectors.
  localparam int PORT_A = 3;
  localparam int PORT_B = 2;
  localparam int PORT_M = 1;
  localparam int PORT_P = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : mollusc_pkg

// File: rtl/scoreboard_entry.sv
// One pending-result down-counter for a single architectural register.
module scoreboard_entry
  import mollusc_pkg::*;
#(
  parameter int LAT_W = mollusc_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: clear beats hold, hold beats load, load beats decrement.
  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule : scoreboard_entry

// File: rtl/issue_scoreboard.sv
// Register scoreboard: tracks in-flight producers and gates instruction issue
// on RAW and WAW hazards. r0 is hardwired zero and never tracked.
module issue_scoreboard
  import mollusc_pkg::*;
#(
  parameter int NUM_REGS = mollusc_pkg::NUM_REGS,
  parameter int LAT_W    = mollusc_pkg::LAT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_W-1:0]           issue_dest,
  input  logic [LAT_W-1:0]                issue_lat,
  input  logic [NUM_PORTS*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_PORTS-1:0]            src_used,
  input  logic                            pipe_hold,
  input  logic                            flush,
  output logic                            issue_ready,
  output logic [NUM_PORTS-1:0]            stall_src,
  output logic                            stall_waw,
  output logic [NUM_REGS-1:0]             busy_mask
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic                           accept;

  // r0 has no producer to wait for.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    scoreboard_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (flush),
      .hold_i     (pipe_hold),
      .load_i     (accept && (issue_dest == REG_ADDR_W'(i))),
      .load_val_i (issue_lat),
      .cnt_o      (cnt[i]),
      .busy_o     (busy[i])
    );
  end

  // Hazard detection against pre-edge counters; a counter at 1 still blocks.
  always_comb begin
    stall_src = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      reg_addr_t rd_addr;
      rd_addr      = src_addr[k*REG_ADDR_W +: REG_ADDR_W];
      stall_src[k] = src_used[k] && (rd_addr != '0) && (cnt[rd_addr] != '0);
    end
    // A later write must not land before an older, slower one to the same register.
    stall_waw = issue_valid && (issue_dest != '0) && (cnt[issue_dest] > issue_lat);
    if (rst) begin
      stall_src = '0;
      stall_waw = 1'b0;
    end
  end

  assign issue_ready = !rst && !pipe_hold && !flush && (stall_src == '0) && !stall_waw;
  assign accept      = issue_valid && issue_ready;
  assign busy_mask   = rst ? '0 : busy;

endmodule : issue_scoreboard

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus a
// randomized run against a ready-time reference model.
module tb_issue_scoreboard;
  import mollusc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic [1:0]  issue_lat;
  logic [15:0] src_addr;
  logic [3:0]  src_used;
  logic        pipe_hold;
  logic        flush;
  logic        issue_ready;
  logic [3:0]  stall_src;
  logic        stall_waw;
  logic [15:0] busy_mask;

  int n_checks = 0;
  int n_errors = 0;

  // Model: t counts pipeline-advancing edges; ready_at[r] is the value of t
  // at which register r's result becomes forwardable.
  int t;
  int ready_at[16];

  logic [3:0]  e_src;
  logic        e_waw;
  logic        e_ready;
  logic [15:0] e_busy;

  issue_scoreboard #(.NUM_REGS(16), .LAT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_lat   (issue_lat),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .pipe_hold   (pipe_hold),
    .flush       (flush),
    .issue_ready (issue_ready),
    .stall_src   (stall_src),
    .stall_waw   (stall_waw),
    .busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  function automatic int pend(input logic [3:0] r);
    if (r == 4'd0) return 0;
    return (ready_at[r] > t) ? ready_at[r] - t : 0;
  endfunction

  task automatic model_clear();
    t = 0;
    for (int r = 0; r < 16; r++) ready_at[r] = 0;
  endtask

  task automatic predict();
    e_busy = '0;
    for (int r = 1; r < 16; r++) e_busy[r] = (pend(4'(r)) != 0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] a;
      a = src_addr[k*4 +: 4];
      e_src[k] = src_used[k] && (pend(a) != 0);
    end
    e_waw   = issue_valid && (pend(issue_dest) > int'(issue_lat));
    e_ready = !pipe_hold && !flush && (e_src == 4'b0) && !e_waw;
    if (rst) begin
      e_busy = '0; e_src = '0; e_waw = 1'b0; e_ready = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] l,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                       input logic [3:0] p, input logic [3:0] used,
                       input logic hold, input logic fl);
    issue_valid = v; issue_dest = d; issue_lat = l;
    src_addr[PORT_A*4 +: 4] = a; src_addr[PORT_B*4 +: 4] = b;
    src_addr[PORT_M*4 +: 4] = m; src_addr[PORT_P*4 +: 4] = p;
    src_used = used; pipe_hold = hold; flush = fl;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge; the model decides acceptance from its own prediction.
  task automatic tick();
    logic acc;
    predict();
    acc = issue_valid && e_ready;
    @(posedge clk);
    if (rst || flush) begin
      model_clear();
    end else if (!pipe_hold) begin
      if (acc && issue_dest != 4'd0) ready_at[issue_dest] = t + 1 + int'(issue_lat);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd4, 2'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'hF, 1'b0, 1'b1);
    n_checks++;
    if ({issue_ready, stall_waw, stall_src, busy_mask} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready=%b waw=%b src=%b busy=%h required all zero",
               issue_ready, stall_waw, stall_src, busy_mask);
    end
    tick();
    rst = 1'b0;
    idle();
    n_checks++;
    if (issue_ready !== 1'b1 || busy_mask !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_release: got ready=%b busy=%h required ready=1 busy=0000",
               issue_ready, busy_mask);
    end
  endtask

  task automatic test_raw_latency();
    drive(1'b1, 4'd5, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL raw_producer: got ready=%b required 1", issue_ready);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'd0, 2'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0, 1'b0);
      n_checks++;
      if (stall_src !== ((c < 2) ? 4'b1000 : 4'b0000) || issue_ready !== (c == 2) ||
          busy_mask[5] !== (c < 2)) begin
        n_errors++;
        $display("FAIL raw_cycle%0d: got src=%b ready=%b busy5=%b required src=%b ready=%b busy5=%b",
                 c, stall_src, issue_ready, busy_mask[5], (c < 2) ? 4'b1000 : 4'b0000,
                 c == 2, c < 2);
      end
      tick();
    end
  endtask

  task automatic test_waw();
    drive(1'b1, 4'd3, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'd3, 2'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
      n_checks++;
      if (stall_waw !== (c < 2) || issue_ready !== (c == 2)) begin
        n_errors++;
        $display("FAIL waw_cycle%0d: got waw=%b ready=%b required waw=%b ready=%b",
                 c, stall_waw, issue_ready, c < 2, c == 2);
      end
      tick();
    end
    // The younger write reloaded cnt[3] with 1: busy one more cycle, then free.
    for (int c = 0; c < 2; c++) begin
      idle();
      n_checks++;
      if (busy_mask[3] !== (c == 0)) begin
        n_errors++;
        $display("FAIL waw_reload%0d: got busy3=%b required %b", c, busy_mask[3], c == 0);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd7, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'd0, 2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b1, 1'b0);
      n_checks++;
      if (busy_mask[7] !== 1'b1 || issue_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: got busy7=%b ready=%b required busy7=1 ready=0",
                 c, busy_mask[7], issue_ready);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'd0, 2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0, 1'b0);
      n_checks++;
      if (stall_src[PORT_A] !== (c < 2) || issue_ready !== (c == 2)) begin
        n_errors++;
        $display("FAIL hold_release%0d: got srcA=%b ready=%b required srcA=%b ready=%b",
                 c, stall_src[PORT_A], issue_ready, c < 2, c == 2);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'd9, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd10, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd11, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b1, 1'b1);
    n_checks++;
    if (issue_ready !== 1'b0 || busy_mask !== 16'h0600) begin
      n_errors++;
      $display("FAIL flush_cycle: got ready=%b busy=%h required ready=0 busy=0600",
               issue_ready, busy_mask);
    end
    tick();
    drive(1'b1, 4'd0, 2'd0, 4'd9, 4'd10, 4'd0, 4'd0, 4'b1100, 1'b0, 1'b0);
    n_checks++;
    if (busy_mask !== 16'h0 || stall_src !== 4'b0 || issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_after: got busy=%h src=%b ready=%b required busy=0000 src=0000 ready=1",
               busy_mask, stall_src, issue_ready);
    end
    tick();
  endtask

  task automatic test_zero_regs();
    drive(1'b1, 4'd6, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    // r6 is pending, but it is only named on unused ports.
    drive(1'b1, 4'd0, 2'd3, 4'd0, 4'd0, 4'd6, 4'd6, 4'b1100, 1'b0, 1'b0);
    n_checks++;
    if (stall_src !== 4'b0 || stall_waw !== 1'b0 || issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_srcs: got src=%b waw=%b ready=%b required src=0000 waw=0 ready=1",
               stall_src, stall_waw, issue_ready);
    end
    tick();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0040) begin
      n_errors++;
      $display("FAIL zero_dest: got busy=%h required 0040", busy_mask);
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd4, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 4'd8, 2'd1, 4'd4, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0, 1'b1);
    n_checks++;
    if ({issue_ready, stall_waw, stall_src, busy_mask} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got ready=%b waw=%b src=%b busy=%h required all zero",
               issue_ready, stall_waw, stall_src, busy_mask);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd0, 2'd0, 4'd4, 4'd8, 4'd0, 4'd0, 4'b1100, 1'b0, 1'b0);
    n_checks++;
    if (issue_ready !== 1'b1 || busy_mask !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_mid_release: got ready=%b busy=%h required ready=1 busy=0000",
               issue_ready, busy_mask);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), 2'($urandom),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0);
      predict();
      n_checks++;
      if (stall_src !== e_src || stall_waw !== e_waw || issue_ready !== e_ready ||
          busy_mask !== e_busy) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got src=%b waw=%b ready=%b busy=%h required src=%b waw=%b ready=%b busy=%h",
                 c, stall_src, stall_waw, issue_ready, busy_mask, e_src, e_waw, e_ready, e_busy);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_dest = '0; issue_lat = '0;
    src_addr = '0; src_used = '0; pipe_hold = 1'b0; flush = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_raw_latency();
    test_waw();
    test_hold();
    test_flush();
    test_zero_regs();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_issue_scoreboard

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter NUM_REGS, 16: architectural register count; r0 is hardwired zero and is never tracked.
REQ-002 Parameter LAT_W, 2: width of the per-register pending counter and of issue_lat.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 issue_valid  input  1  decode presents an instruction this cycle.
REQ-006 issue_dest  input  4  destination register address; 0 means no write.
REQ-007 issue_lat  input  LAT_W  cycles until the result becomes forwardable (0 = forwardable to the next instruction).
REQ-008 src_addr  input  4x4  A, B, M, P read addresses, packed {a,b,m,p}.
REQ-009 src_used  input  4  per-port valid bits in the same order.
REQ-010 pipe_hold  input  1  downstream stall; pipeline and scoreboard freeze.
REQ-011 flush  input  1  squash all in-flight producers (branch or trap).
REQ-012 issue_ready  output  1  instruction may issue this cycle.
REQ-013 stall_src  output  4  per-port RAW-blocked flags, {a,b,m,p}.
REQ-014 stall_waw  output  1  blocked by a WAW ordering hazard.
REQ-015 busy_mask  output  16  bit i set when cnt[i] is nonzero; bit 0 is always 0.

Function
REQ-016 Keep one LAT_W-bit down-counter cnt[i] per register i = 1..15.
REQ-017 stall_src[k] = src_used[k] and (src_addr[k] != 0) and (cnt[src_addr[k]] != 0), combinational from current state.
REQ-018 stall_waw = issue_valid and (issue_dest != 0) and (cnt[issue_dest] > issue_lat).
REQ-019 issue_ready = !rst and !pipe_hold and !flush and (stall_src == 0) and !stall_waw; it does not depend on issue_valid.
REQ-020 accept = issue_valid and issue_ready.
REQ-021 Each edge with pipe_hold = 0 and no flush: every nonzero cnt decrements by 1, saturating at 0.
REQ-022 On accept with issue_dest != 0, cnt[issue_dest] loads issue_lat, overriding that register's decrement in the same edge.
REQ-023 Resulting latency: after accept with issue_lat = L, a dependent read is blocked for exactly L cycles and issues on the (L+1)th cycle.
REQ-024 Hazard checks use pre-edge counter values, so an instruction whose source equals its own destination checks the older producer only.
REQ-025 With pipe_hold = 1, all counters hold their values and no accept occurs.
REQ-026 flush = 1 clears all counters at the edge, overrides pipe_hold and any accept, and forces issue_ready = 0 in that cycle.
REQ-027 issue_dest = 0 never modifies state; src_addr = 0 never stalls.
REQ-028 A cnt value of 1 that is decrementing this edge still stalls readers in the current cycle.

Reset
REQ-029 While rst = 1: at the edge all counters go to 0; in the same cycle issue_ready = 0, busy_mask = 0, stall_waw = 0, and stall_src = 0.
REQ-030 rst has priority over flush, pipe_hold and accept.
REQ-031 rst asserted mid-operation discards all pending state; the first cycle after deassertion has issue_ready = 1 when pipe_hold = 0 and flush = 0.

Structure
REQ-032 The shared package mollusc_pkg holds REG_ADDR_W = 4, NUM_REGS = 16, LAT_W = 2, and the port-index constants PORT_A = 3, PORT_B = 2, PORT_M = 1, PORT_P = 0.
REQ-033 Sub-module scoreboard_entry is instantiated 15 times; each instance holds one counter with load, decrement, hold and clear controls and a busy output.
REQ-034 Port ordering {a,b,m,p} matches the register file read ports.

Verification
REQ-035 Issue dest r5, lat 2; next cycle issue with src_a = r5 -> stall_src = 4'b1000 for 2 cycles, accepted on the 3rd, busy_mask[5] cleared at the same time.
REQ-036 Issue dest r3, lat 3; then issue dest r3, lat 1 -> stall_waw = 1 until cnt[3] <= 1, then accept with cnt[3] = 1.
REQ-037 Issue dest r7, lat 2; pipe_hold for 4 cycles, then a reader of r7 -> busy_mask[7] held for 4 cycles; reader stalls 2 more cycles after hold release.
REQ-038 Issue dest r9 and r10, lat 3; flush next cycle -> busy_mask = 0 after the edge; a reader of r9 issues in the following cycle.
REQ-039 Sources r0 or src_used = 0 with arbitrary cnt, and issue dest r0 lat 3 -> no stall, busy_mask[0] = 0.
REQ-040 rst asserted while cnt[4] = 2 with flush and issue_valid active -> issue_ready = 0 in that cycle, all counters 0, and ready in the first cycle after deassertion.
